// File: rtl/random_request_arbiter.sv
// Round-robin arbiter that shares one random-number generator among N_REQ requesters.
// Each service toggles the generator trigger, waits for the output to settle, then returns one value.
module random_request_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] req,
  input  logic [7:0]       rng_value,
  output logic             rng_trigger,
  output logic [N_REQ-1:0] grant,
  output logic [7:0]       rand_data,
  output logic             rand_valid,
  output logic             busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DELIVER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [N_REQ-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trig_q, trig_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   eff_req;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_next;

  assign eff_req = req & ~mask_q;

  // First requesting index scanning ptr, ptr+1, ... with wraparound.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && eff_req[PTR_W'((32'(ptr_q) + i) % N_REQ)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((32'(ptr_q) + i) % N_REQ);
      end
    end
  end

  assign ptr_next = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    trig_d  = trig_q;
    grant_d = grant_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        // The mask only ever covers a single IDLE cycle.
        mask_d  = '0;
        grant_d = '0;
        if (win_found) begin
          win_d   = win_idx;
          grant_d = N_REQ'(1) << win_idx;
          trig_d  = ~trig_q;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d  = rng_value;
          valid_d = 1'b1;
          state_d = DELIVER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DELIVER: begin
        valid_d = 1'b0;
        grant_d = '0;
        ptr_d   = ptr_next;
        mask_d  = N_REQ'(1) << win_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign rng_trigger = trig_q;
  assign grant       = grant_q;
  assign rand_data   = data_q;
  assign rand_valid  = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_random_request_arbiter.sv
// Bench for random_request_arbiter: stand-in generator, transaction-level model, scoreboard monitor.
module tb_random_request_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [7:0]   rng_value;
  logic         rng_trigger;
  logic [N-1:0] grant;
  logic [7:0]   rand_data;
  logic         rand_valid;
  logic         busy;

  always #5 clk = ~clk;

  random_request_arbiter #(.N_REQ(N), .SETTLE_CYCLES(S)) dut (
    .CLOCK      (clk),
    .RESET      (rst),
    .req        (req),
    .rng_value  (rng_value),
    .rng_trigger(rng_trigger),
    .grant      (grant),
    .rand_data  (rand_data),
    .rand_valid (rand_valid),
    .busy       (busy)
  );

  // Generator stand-in: advances to the next table value one cycle after each trigger flip.
  logic [7:0]  gen_table [0:255];
  int unsigned gen_flips = 0;
  logic        trig_seen = 1'b0;

  always @(posedge clk) begin
    if (rng_trigger != trig_seen) begin
      trig_seen <= rng_trigger;
      gen_flips <= gen_flips + 1;
    end
  end

  assign rng_value = (gen_flips == 0) ? 8'd7 : gen_table[8'(gen_flips - 1)];

  typedef struct {
    logic [N-1:0] g;
    logic [7:0]   d;
    int unsigned  cyc;
  } exp_t;

  exp_t         exp_q[$];
  int unsigned  m_cyc   = 0;
  int unsigned  m_busy  = 0;
  int unsigned  m_ptr   = 0;
  int unsigned  m_win   = 0;
  int unsigned  m_flips = 0;
  logic [N-1:0] m_mask  = '0;
  logic         m_trig  = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference: one service = grant, S settle cycles, one deliver cycle, then a masked idle cycle.
  task automatic model_step();
    logic [N-1:0] eff;
    logic         found;
    exp_t         e;
    m_cyc++;
    if (rst) begin
      if (m_trig) m_flips++;
      m_trig = 1'b0;
      m_busy = 0;
      m_ptr  = 0;
      m_mask = '0;
      exp_q.delete();
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_ptr  = (m_win + 1) % N;
        m_mask = N'(1) << m_win;
      end
    end else begin
      eff    = req & ~m_mask;
      m_mask = '0;
      found  = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && eff[(m_ptr + i) % N]) begin
          found = 1'b1;
          m_win = (m_ptr + i) % N;
        end
      end
      if (found) begin
        m_trig = ~m_trig;
        m_flips++;
        e.g    = N'(1) << m_win;
        e.d    = gen_table[8'(m_flips - 1)];
        e.cyc  = m_cyc + S;
        exp_q.push_back(e);
        m_busy = S + 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: per-cycle status check plus scoreboard pop on every rand_valid.
  initial begin
    logic [N-1:0] exp_grant;
    exp_t         e;
    forever begin
      @(negedge clk);
      exp_grant = (m_busy > 0) ? (N'(1) << m_win) : '0;
      checks++;
      if (rng_trigger !== m_trig || busy !== (m_busy > 0) || grant !== exp_grant || !$onehot0(grant)) begin
        errors++;
        $display("FAIL status cyc=%0d trig=%b exp %b busy=%b exp %b grant=%b exp %b",
                 m_cyc, rng_trigger, m_trig, busy, (m_busy > 0), grant, exp_grant);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < m_cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_valid cyc=%0d expected rand_valid at cyc %0d grant %b", m_cyc, exp_q[0].cyc, exp_q[0].g);
        void'(exp_q.pop_front());
      end
      if (rand_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid cyc=%0d grant=%b data=%0d, required no rand_valid", m_cyc, grant, rand_data);
        end else begin
          e = exp_q.pop_front();
          if (grant !== e.g || rand_data !== e.d || m_cyc != e.cyc) begin
            errors++;
            $display("FAIL delivery cyc=%0d grant=%b data=%0d, required cyc=%0d grant=%b data=%0d",
                     m_cyc, grant, rand_data, e.cyc, e.g, e.d);
          end
        end
      end
    end
  end

  task automatic wait_valid(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (rand_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_valid timeout: rand_valid=0 after %0d cycles, required 1", bound);
    end
  endtask

  task automatic wait_settling(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (busy && !rand_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_settling timeout: busy=%b after %0d cycles, required 1", busy, bound);
    end
  endtask

  initial begin
    gen_table[0] = 8'd50;
    gen_table[1] = 8'd17;
    gen_table[2] = 8'd34;
    for (int i = 3; i < 256; i++) gen_table[i] = 8'($urandom_range(1, 127));

    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Lone requester: back-to-back services spaced by the masked idle cycle.
    req = 4'b0001;
    repeat (14) @(negedge clk);
    req = '0;
    repeat (6) @(negedge clk);

    // All requesters held: round-robin rotation.
    req = 4'b1111;
    repeat (30) @(negedge clk);
    req = '0;
    repeat (6) @(negedge clk);

    // Drop on delivery while another requester rises in the same cycle.
    req = 4'b0100;
    wait_valid(50);
    req = 4'b0010;
    repeat (10) @(negedge clk);
    req = '0;
    repeat (6) @(negedge clk);

    // Reset during settling aborts the service; pointer returns to requester 0.
    req = 4'b0110;
    wait_settling(50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    repeat (12) @(negedge clk);
    req = '0;
    repeat (6) @(negedge clk);

    // Random traffic with occasional resets.
    repeat (800) begin
      @(negedge clk);
      if (rand_valid && $urandom_range(0, 1) == 1) req = req & ~grant;
      if ($urandom_range(0, 3) == 0) req = req | N'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) req = req & ~N'($urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
    end

    rst = 1'b0;
    req = '0;
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d deliveries outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
